// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC scan scheduler and the ADC datapath.
//   sched_state_t : scan scheduler FSM state encoding
//   SAR_DATA_W    : default ADC code width, shared with the ADC datapath
package sar_pkg;

  localparam int unsigned SAR_DATA_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_TRACK   = 3'd2,
    ST_CONVERT = 3'd3,
    ST_OUTPUT  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/sar_chan_picker.sv
// Combinational finder for the lowest set bit of mask at index >= ptr.
//   mask  : latched channel enable mask
//   ptr   : first index eligible for selection (may equal NUM_CH = none left)
//   found : a set bit exists at or above ptr
//   index : lowest such bit position (0 when found is low)
module sar_chan_picker
  import sar_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]           mask,
  input  logic [$clog2(NUM_CH+1)-1:0] ptr,
  output logic                        found,
  output logic [$clog2(NUM_CH)-1:0]   index
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned PTR_W = $clog2(NUM_CH + 1);

  // Scan downwards so the last hit written is the lowest qualifying index.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (PTR_W'(i) >= ptr)) begin
        found = 1'b1;
        index = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/sar_scan_scheduler.sv
// Round-robin scan controller sharing one SAR ADC among NUM_CH channels.
//   clk, reset           : clock, synchronous active-high reset
//   start, continuous    : begin a pass (IDLE only) / auto-restart at pass end
//   ch_enable            : channel mask, latched at each pass start
//   adc_mux_sel,adc_hold : analog mux select, 0 = track / 1 = hold-convert
//   adc_eoc, adc_code    : ADC end-of-conversion level and result code
//   res_valid/ready/channel/data : tagged result, valid/ready handshake
//   busy, timeout_err    : not IDLE / sticky conversion-abort flag
module sar_scan_scheduler
  import sar_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned DATA_W        = SAR_DATA_W,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned CONV_TIMEOUT  = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [NUM_CH-1:0]         ch_enable,
  output logic [$clog2(NUM_CH)-1:0] adc_mux_sel,
  output logic                      adc_hold,
  input  logic                      adc_eoc,
  input  logic [DATA_W-1:0]         adc_code,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(NUM_CH)-1:0] res_channel,
  output logic [DATA_W-1:0]         res_data,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned PTR_W = $clog2(NUM_CH + 1);
  localparam int unsigned TRK_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int unsigned TO_W  = $clog2(CONV_TIMEOUT);

  sched_state_t      state;
  logic [NUM_CH-1:0] mask_q;
  logic [PTR_W-1:0]  ptr;
  logic [TRK_W-1:0]  trk_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              eoc_q;
  logic              eoc_rise;
  logic              pick_found;
  logic [CH_W-1:0]   pick_index;

  sar_chan_picker #(.NUM_CH(NUM_CH)) u_picker (
    .mask  (mask_q),
    .ptr   (ptr),
    .found (pick_found),
    .index (pick_index)
  );

  // eoc_q tracks adc_eoc every cycle, so a level already high on CONVERT entry is no edge.
  assign eoc_rise = adc_eoc & ~eoc_q;

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      mask_q      <= '0;
      ptr         <= '0;
      trk_cnt     <= '0;
      to_cnt      <= '0;
      eoc_q       <= 1'b0;
      adc_mux_sel <= '0;
      adc_hold    <= 1'b0;
      res_valid   <= 1'b0;
      res_channel <= '0;
      res_data    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      eoc_q <= adc_eoc;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mask_q      <= ch_enable;
            timeout_err <= 1'b0;
            ptr         <= '0;
            busy        <= 1'b1;
            state       <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (pick_found) begin
            adc_mux_sel <= pick_index;
            ptr         <= PTR_W'(pick_index) + PTR_W'(1);
            trk_cnt     <= '0;
            state       <= ST_TRACK;
          end else if (continuous) begin
            // Pass ends; restart from channel 0 with a fresh mask.
            mask_q <= ch_enable;
            ptr    <= '0;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_TRACK: begin
          if (trk_cnt == TRK_W'(SAMPLE_CYCLES - 1)) begin
            adc_hold <= 1'b1;
            to_cnt   <= '0;
            state    <= ST_CONVERT;
          end else begin
            trk_cnt <= trk_cnt + TRK_W'(1);
          end
        end
        ST_CONVERT: begin
          if (eoc_rise) begin
            res_data    <= adc_code;
            res_channel <= adc_mux_sel;
            res_valid   <= 1'b1;
            adc_hold    <= 1'b0;
            state       <= ST_OUTPUT;
          end else if (to_cnt == TO_W'(CONV_TIMEOUT - 1)) begin
            // Abort: flag the error, drop this channel, continue the pass.
            timeout_err <= 1'b1;
            adc_hold    <= 1'b0;
            state       <= ST_SELECT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_SELECT;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_scan_scheduler.sv
// Self-checking bench for sar_scan_scheduler with an ADC behavioural model
// and a result scoreboard fed by each scenario task.
module tb_sar_scan_scheduler;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 10;
  localparam int unsigned CH_W   = 2;
  localparam int EOC_DELAY       = 12;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              continuous = 1'b0;
  logic [NUM_CH-1:0] ch_enable = '0;
  logic [CH_W-1:0]   adc_mux_sel;
  logic              adc_hold;
  logic              adc_eoc = 1'b0;
  logic [DATA_W-1:0] adc_code = '0;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [CH_W-1:0]   res_channel;
  logic [DATA_W-1:0] res_data;
  logic              busy;
  logic              timeout_err;

  int errors = 0;
  int checks = 0;

  // Scoreboard entry: {channel, data}
  logic [CH_W+DATA_W-1:0] exp_q[$];
  int n_results = 0;
  int hold_rises = 0;
  bit eoc_stuck = 1'b0;
  int adc_cnt = 0;
  logic vld_prev = 1'b0;
  logic hold_prev = 1'b0;

  sar_scan_scheduler #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SAMPLE_CYCLES(2), .CONV_TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .ch_enable(ch_enable), .adc_mux_sel(adc_mux_sel), .adc_hold(adc_hold),
    .adc_eoc(adc_eoc), .adc_code(adc_code), .res_valid(res_valid),
    .res_ready(res_ready), .res_channel(res_channel), .res_data(res_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // ADC model: eoc rises EOC_DELAY cycles into hold, code = 0x100 + channel.
  always @(negedge clk) begin
    if (adc_hold) begin
      adc_cnt = adc_cnt + 1;
      if (adc_cnt == EOC_DELAY && !eoc_stuck) begin
        adc_eoc  = 1'b1;
        adc_code = DATA_W'(10'h100 + 10'(adc_mux_sel));
      end
    end else begin
      adc_cnt = 0;
      adc_eoc = 1'b0;
    end
    if (adc_hold && !hold_prev) hold_rises = hold_rises + 1;
    hold_prev = adc_hold;
  end

  // Result monitor: each new res_valid pulse is popped against the scoreboard.
  always @(negedge clk) begin
    if (res_valid && !vld_prev && !reset) begin
      n_results = n_results + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_result: got ch=%0d data=%h, required none", res_channel, res_data);
      end else begin
        logic [CH_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({res_channel, res_data} !== e) begin
          errors = errors + 1;
          $display("FAIL result: got ch=%0d data=%h, required ch=%0d data=%h",
                   res_channel, res_data, e[CH_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
    vld_prev = res_valid;
  end

  function automatic logic [CH_W+DATA_W-1:0] exp_entry(input int ch);
    return {CH_W'(ch), DATA_W'(10'h100 + 10'(ch))};
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%b, required 0", name, busy);
    end
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] mask);
    @(negedge clk);
    ch_enable = mask;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({adc_hold, adc_mux_sel, res_valid, res_channel, res_data, busy, timeout_err} !== '0) begin
      errors++;
      $display("FAIL %s: hold=%b sel=%0d vld=%b ch=%0d data=%h busy=%b terr=%b, required all 0",
               name, adc_hold, adc_mux_sel, res_valid, res_channel, res_data, busy, timeout_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    reset = 1'b0;
  endtask

  task automatic test_basic_scan();
    res_ready = 1'b1;
    exp_q.push_back(exp_entry(0));
    exp_q.push_back(exp_entry(1));
    exp_q.push_back(exp_entry(3));
    pulse_start(4'b1011);
    // Now at cycle t+1: SELECT, busy high, hold low.
    checks++;
    if (busy !== 1'b1 || adc_hold !== 1'b0) begin
      errors++;
      $display("FAIL start_select: busy=%b hold=%b, required 1 0", busy, adc_hold);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (adc_hold !== 1'b0 || adc_mux_sel !== 2'd0) begin
      errors++;
      $display("FAIL track_phase: hold=%b sel=%0d, required 0 0", adc_hold, adc_mux_sel);
    end
    @(negedge clk);
    checks++;
    if (adc_hold !== 1'b1) begin
      errors++;
      $display("FAIL hold_rise: hold=%b, required 1 at t+4", adc_hold);
    end
    wait_idle("basic");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_missing: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_continuous();
    int base = n_results;
    int n = 0;
    continuous = 1'b1;
    repeat (4) exp_q.push_back(exp_entry(2));
    pulse_start(4'b0100);
    while (n_results < base + 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    // Drop continuous mid-pass during the fourth conversion.
    n = 0;
    while (adc_hold !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    continuous = 1'b0;
    wait_idle("continuous");
    checks++;
    if (n_results != base + 4) begin
      errors++;
      $display("FAIL continuous_count: got %0d results, required 4", n_results - base);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [CH_W-1:0] ch0;
    logic [DATA_W-1:0] d0;
    int n = 0;
    int bad = 0;
    int rises;
    res_ready = 1'b0;
    exp_q.push_back(exp_entry(1));
    pulse_start(4'b0010);
    while (res_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ch0 = res_channel;
    d0 = res_data;
    rises = hold_rises;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_channel !== ch0 || res_data !== d0 ||
          adc_hold !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || hold_rises != rises || d0 !== 10'h101) begin
      errors++;
      $display("FAIL backpressure_stable: %0d unstable cycles, data=%h, required 0 and 101", bad, d0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_accept: res_valid=%b, required 0", res_valid);
    end
    wait_idle("backpressure");
  endtask

  task automatic test_timeout();
    int n = 0;
    int high = 0;
    res_ready = 1'b1;
    eoc_stuck = 1'b1;
    exp_q.push_back(exp_entry(1));
    pulse_start(4'b0011);
    while (adc_hold !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    while (adc_hold === 1'b1 && high < 200) begin
      checks++;
      if (timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_early: timeout_err=%b in convert cycle %0d, required 0", timeout_err, high + 1);
      end
      @(negedge clk);
      high++;
    end
    eoc_stuck = 1'b0;
    checks++;
    if (high != 64 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_abort: convert cycles=%0d terr=%b, required 64 1", high, timeout_err);
    end
    wait_idle("timeout");
    checks++;
    if (timeout_err !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_sticky: terr=%b outstanding=%0d, required 1 0", timeout_err, exp_q.size());
    end
  endtask

  task automatic test_empty_mask();
    int rises = hold_rises;
    int res0 = n_results;
    pulse_start(4'b0000);
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL empty_select: busy=%b terr=%b, required 1 0", busy, timeout_err);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_idle: busy=%b, required 0", busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (hold_rises != rises || n_results != res0) begin
      errors++;
      $display("FAIL empty_activity: hold pulses=%0d results=%0d, required 0 0",
               hold_rises - rises, n_results - res0);
    end
  endtask

  task automatic test_reset_midway();
    int n = 0;
    res_ready = 1'b1;
    pulse_start(4'b1111);
    while (adc_hold !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_in_convert");
    reset = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
    exp_q.push_back(exp_entry(0));
    pulse_start(4'b1111);
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_in_output");
    reset = 1'b0;
    res_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back(exp_entry(2));
    exp_q.push_back(exp_entry(3));
    pulse_start(4'b1100);
    wait_idle("after_reset");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL after_reset_scan: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_continuous();
    test_backpressure();
    test_timeout();
    test_empty_mask();
    test_reset_midway();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sar_scan_scheduler.md
# sar_scan_scheduler

Round-robin scan controller that shares one SAR ADC (sample-and-hold, comparator, SAR register) among several analog channels. It selects a channel, times the track and hold phases, waits for the ADC end-of-conversion, captures the code, and delivers it tagged with its channel over a valid/ready result port. It sits between the ADC datapath and the digital consumer, and drives the `input_hold_digital` input of the ADC.

## Interface
- `NUM_CH`, 4: number of analog channels (2..16).
- `DATA_W`, 10: ADC code width.
- `SAMPLE_CYCLES`, 2: track-phase length in `clk` cycles (≥1).
- `CONV_TIMEOUT`, 64: maximum `clk` cycles in CONVERT before abort (≥2).

Ports:
- `clk`  in  1  system clock. One clock.
- `reset`  in  1  reset; synchronous and active-high.
- `start`  in  1  one-cycle request to begin a scan pass; honoured only in IDLE.
- `continuous`  in  1  when high at the end of a pass, the next pass begins immediately.
- `ch_enable`  in  NUM_CH  channel mask, latched at the start of each pass.
- `adc_mux_sel`  out  $clog2(NUM_CH)  analog mux select.
- `adc_hold`  out  1  to ADC `input_hold_digital`: 0 = track, 1 = hold/convert.
- `adc_eoc`  in  1  ADC end-of-conversion, level; may be from a divided-clock domain but is treated as synchronous to `clk`.
- `adc_code`  in  DATA_W  ADC result, valid while `adc_eoc` is high.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_channel`  out  $clog2(NUM_CH)  channel of the result.
- `res_data`  out  DATA_W  captured code.
- `busy`  out  1  high in any state other than IDLE.
- `timeout_err`  out  1  sticky; set on a conversion abort; cleared by reset or an accepted `start`.

## Operation
- FSM states: IDLE, SELECT, TRACK, CONVERT, OUTPUT.
- IDLE, on `start`:
  - latch `ch_enable` into `mask_q`;
  - clear `timeout_err`;
  - go to SELECT with `ptr` = 0.
- SELECT:
  - find the lowest index ≥ `ptr` with `mask_q` bit set;
  - if one is found: set `adc_mux_sel` to it, set `ptr` to index+1, go to TRACK;
  - if none is found, the pass ends: if `continuous`=1, re-latch `ch_enable`, set `ptr` to 0 and stay in SELECT; otherwise go to IDLE;
  - an all-zero mask completes the pass immediately.
- TRACK:
  - `adc_hold`=0 for exactly SAMPLE_CYCLES cycles;
  - then go to CONVERT and clear the timeout counter.
- CONVERT:
  - `adc_hold`=1;
  - `eoc_q` registers `adc_eoc` every cycle; a rising edge is `adc_eoc & ~eoc_q`;
  - on a rising edge: capture `adc_code` and `adc_mux_sel` into `res_data`/`res_channel`, go to OUTPUT;
  - if the counter reaches CONV_TIMEOUT-1 with no edge: set `timeout_err`, produce no result, go to SELECT;
  - `eoc` already high on entry does not count as an edge.
- OUTPUT:
  - `res_valid`=1 and `adc_hold`=0; `adc_mux_sel` is held;
  - when `res_valid & res_ready`: drop `res_valid` and go to SELECT.
- `start` outside IDLE is ignored.
- `continuous` falling mid-pass lets the current pass finish.
- `ch_enable` changes mid-pass take effect only at the next pass.
- Channels are served in ascending index order within a pass; `ptr` wraps by pass restart, never by modulo.

## Timing
- Reset values: `adc_hold`=0, `adc_mux_sel`=0, `res_valid`=0, `res_channel`=0, `res_data`=0, `busy`=0, `timeout_err`=0. State is IDLE, `ptr`=0, `mask_q`=0, `eoc_q`=0.
- Reset mid-conversion aborts immediately; the next cycle shows the reset values.
- With `start` at cycle t:
  - SELECT at t+1 (`busy`=1);
  - TRACK from t+2 through t+1+SAMPLE_CYCLES;
  - `adc_hold` rises at t+2+SAMPLE_CYCLES.
- Eoc rising edge at cycle e: `res_valid`=1 at e+1.
- Handshake completing at cycle h: SELECT at h+1, next TRACK at h+2.
- Back-to-back channel overhead with `res_ready` held high: 2 cycles, plus SAMPLE_CYCLES, plus conversion time.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- A shared `sar_pkg` holds:
  - the state enum `sched_state_t`;
  - the default `DATA_W` constant, shared with the ADC datapath.
- One sub-module, `sar_chan_picker`: combinational lowest-set-bit-at-or-above-`ptr` finder over `mask_q`, returning `found` and `index`.
- The timers (track count, timeout count) live in the top module.

## Test plan
- NUM_CH=4, `ch_enable`=4'b1011, `start`, eoc model returns code=0x100+ch after 12 cycles, `res_ready`=1 → results on channels 0, 1, 3 with data 0x100, 0x101, 0x103; returns to IDLE; `busy` falls.
- `continuous`=1, `ch_enable`=4'b0100 → channel 2 is repeated indefinitely; dropping `continuous` → exactly one more result, then IDLE.
- `res_ready`=0 for 20 cycles after a result → `res_valid`, `res_data` and `res_channel` stable; `adc_hold`=0; no new TRACK starts until acceptance.
- `adc_eoc` stuck at 0, CONV_TIMEOUT=64 → `timeout_err`=1 at cycle 64 of CONVERT; no result for that channel; the next enabled channel proceeds; the next `start` clears the error.
- `ch_enable`=0 with `start` → SELECT then IDLE within 2 cycles; no `adc_hold` pulse; no result.
- `reset` asserted during CONVERT and during OUTPUT → all outputs at their reset values the next cycle; a subsequent `start` scans from channel 0.
